// File: rtl/wb_trace_if.sv
// Writeback observation and trace-drain bundle for wb_trace_monitor.
// The master side drives the register-file writeback and consumes the trace port.
// The slave side (the monitor) samples the writeback and presents the FIFO head.
interface wb_trace_if #(
  parameter int WORD  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic             wb_en;
  logic [RA_W-1:0]  wb_addr;
  logic [WORD-1:0]  wb_data;
  logic             trace_valid;
  logic             trace_ready;
  logic [RA_W-1:0]  trace_addr;
  logic [WORD-1:0]  trace_data;
  logic [CNT_W-1:0] trace_cycle;

  modport master (
    output wb_en, wb_addr, wb_data, trace_ready,
    input  trace_valid, trace_addr, trace_data, trace_cycle
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, trace_ready,
    output trace_valid, trace_addr, trace_data, trace_cycle
  );
endinterface

// File: rtl/wb_trace_monitor.sv
// Writeback trace monitor for the LEGv8 datapath.
// Captures qualified register-file writes into a small FIFO, raises pass when
// the target value is written back and fail when the run times out.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | not armed; no captures, FIFO still drainable
//  S_RUN  | armed; cycle counter running, qualified writes captured
//  S_PASS | target value seen; counter frozen, waiting for re-arm
//  S_FAIL | timeout reached; counter frozen, waiting for re-arm
module wb_trace_monitor #(
  parameter int WORD    = 64,
  parameter int RA_W    = 5,
  parameter int DEPTH   = 8,
  parameter int TARGET  = 720,
  parameter int TIMEOUT = 500,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  wb_trace_if.slave        bus,
  output logic             overflow,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t state;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;

  logic [RA_W-1:0]  mem_addr  [DEPTH];
  logic [WORD-1:0]  mem_data  [DEPTH];
  logic [CNT_W-1:0] mem_cycle [DEPTH];

  logic arm;
  logic qual;
  logic match;
  logic timeout;
  logic full;
  logic empty;
  logic push;
  logic pop;

  // start only re-arms from a non-running state; a pulse during RUN is ignored
  assign arm     = start && (state != S_RUN);
  // writes to XZR (register 31) never change architectural state, so skip them
  assign qual    = bus.wb_en && (bus.wb_addr != RA_W'(31)) && (state == S_RUN);
  assign match   = qual && (bus.wb_data == WORD'(TARGET));
  assign timeout = (state == S_RUN) && (cycle_count == CNT_W'(TIMEOUT - 1));

  assign full  = (occ == (PTR_W+1)'(DEPTH));
  assign empty = (occ == '0);
  assign pop   = bus.trace_ready && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push  = qual && (!full || pop);

  assign bus.trace_valid = !empty;
  assign bus.trace_addr  = empty ? '0 : mem_addr[rd_ptr];
  assign bus.trace_data  = empty ? '0 : mem_data[rd_ptr];
  assign bus.trace_cycle = empty ? '0 : mem_cycle[rd_ptr];

  // Monitor FSM with registered status outputs and the run cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (match) begin
            state <= S_PASS;
            busy  <= 1'b0;
            pass  <= 1'b1;
          end else if (timeout) begin
            state <= S_FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        default: begin
          if (start) begin
            state       <= S_RUN;
            busy        <= 1'b1;
            pass        <= 1'b0;
            fail        <= 1'b0;
            cycle_count <= '0;
          end
        end
      endcase
    end
  end

  // Trace storage; contents need no reset because the head is masked while empty
  always_ff @(posedge clk) begin
    if (push && !arm) begin
      mem_addr[wr_ptr]  <= bus.wb_addr;
      mem_data[wr_ptr]  <= bus.wb_data;
      mem_cycle[wr_ptr] <= cycle_count;
    end
  end

  // FIFO pointers, occupancy and sticky overflow; re-arm empties the trace
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else if (arm) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (qual && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed testbench for wb_trace_monitor: arm, pass, XZR filtering, overflow,
// timeout, reset mid-run and re-arm.
module tb_wb_trace_monitor;

  logic        tb_clk;
  logic        rst;
  logic        start;
  logic        overflow;
  logic        busy;
  logic        pass;
  logic        fail;
  logic [15:0] cycle_count;

  int total;
  int bad;

  wb_trace_if #(.WORD(64), .RA_W(5), .CNT_W(16)) bus ();

  wb_trace_monitor #(
    .WORD(64), .RA_W(5), .DEPTH(8), .TARGET(720), .TIMEOUT(500), .CNT_W(16)
  ) dut (
    .clk         (tb_clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .overflow    (overflow),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail),
    .cycle_count (cycle_count)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    step();
    bus.wb_en   = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    start = 1'b0;
    bus.wb_en = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    bus.trace_ready = 1'b0;

    // T1 reset and arm
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_valid", bus.trace_valid, 0);
    chk("rst_addr", bus.trace_addr, 0);
    chk("rst_data", bus.trace_data, 0);
    chk("rst_cycle", bus.trace_cycle, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_cc", cycle_count, 0);
    arm();
    chk("arm_busy", busy, 1);
    chk("arm_cc0", cycle_count, 0);
    step();
    chk("arm_cc1", cycle_count, 1);
    step();
    chk("arm_cc2", cycle_count, 2);

    // T2 pass on X2=720, trace yields both writes in order
    wr(5'd1, 64'd1);
    chk("t2_valid_next", bus.trace_valid, 1);
    chk("t2_busy_mid", busy, 1);
    wr(5'd2, 64'd720);
    chk("t2_pass", pass, 1);
    chk("t2_busy", busy, 0);
    chk("t2_fail", fail, 0);
    chk("t2_cc_frozen", cycle_count, 3);
    chk("t2_h0_addr", bus.trace_addr, 1);
    chk("t2_h0_data", bus.trace_data, 1);
    chk("t2_h0_cycle", bus.trace_cycle, 2);
    step();
    chk("t2_hold_data", bus.trace_data, 1);
    chk("t2_cc_still", cycle_count, 3);
    bus.trace_ready = 1'b1;
    step();
    chk("t2_h1_addr", bus.trace_addr, 2);
    chk("t2_h1_data", bus.trace_data, 720);
    chk("t2_h1_cycle", bus.trace_cycle, 3);
    step();
    chk("t2_drained", bus.trace_valid, 0);
    bus.trace_ready = 1'b0;

    // T3 XZR and disabled writes of the target are not captured
    arm();
    chk("t3_pass_clr", pass, 0);
    chk("t3_busy", busy, 1);
    chk("t3_cc0", cycle_count, 0);
    wr(5'd31, 64'd720);
    bus.wb_addr = 5'd5;
    bus.wb_data = 64'd720;
    step();
    chk("t3_pass", pass, 0);
    chk("t3_valid", bus.trace_valid, 0);
    chk("t3_busy2", busy, 1);
    chk("t3_cc2", cycle_count, 2);

    // T4a nine writes into an 8-deep FIFO with no consumer
    for (int i = 0; i < 9; i++) wr(5'(i + 1), 64'(100 + i));
    chk("t4_ovf", overflow, 1);
    chk("t4_valid", bus.trace_valid, 1);
    chk("t4_h_addr", bus.trace_addr, 1);
    chk("t4_h_cycle", bus.trace_cycle, 2);
    bus.trace_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t4_drain", bus.trace_data, 64'(100 + k));
      step();
    end
    chk("t4_empty", bus.trace_valid, 0);
    step();
    chk("t4_empty_pop", bus.trace_valid, 0);
    chk("t4_ovf_sticky", overflow, 1);
    bus.trace_ready = 1'b0;
    wr(5'd3, 64'd720);
    chk("t4_pass", pass, 1);
    chk("t4_match_captured", bus.trace_data, 720);
    arm();
    chk("t4_rearm_ovf", overflow, 0);
    chk("t4_rearm_valid", bus.trace_valid, 0);

    // T4b ninth write at full together with a pop
    for (int i = 0; i < 8; i++) wr(5'(i + 1), 64'(200 + i));
    chk("t4b_full_ovf", overflow, 0);
    bus.trace_ready = 1'b1;
    wr(5'd9, 64'd208);
    bus.trace_ready = 1'b0;
    chk("t4b_ovf", overflow, 0);
    chk("t4b_head", bus.trace_data, 201);
    bus.trace_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t4b_drain", bus.trace_data, 64'(201 + k));
      step();
    end
    chk("t4b_empty", bus.trace_valid, 0);
    bus.trace_ready = 1'b0;

    // T5 timeout, then a match on the last cycle wins
    wr(5'd4, 64'd720);
    chk("t5_pre_pass", pass, 1);
    arm();
    for (int n = 0; n < 499; n++) step();
    chk("t5_cc499", cycle_count, 499);
    chk("t5_busy499", busy, 1);
    chk("t5_fail_early", fail, 0);
    step();
    chk("t5_fail", fail, 1);
    chk("t5_busy", busy, 0);
    chk("t5_pass", pass, 0);
    chk("t5_cc_frozen", cycle_count, 499);
    step();
    chk("t5_cc_frozen2", cycle_count, 499);
    arm();
    chk("t5_rearm_fail", fail, 0);
    chk("t5_rearm_cc", cycle_count, 0);
    for (int n = 0; n < 499; n++) step();
    wr(5'd7, 64'd720);
    chk("t5_late_pass", pass, 1);
    chk("t5_late_fail", fail, 0);
    chk("t5_late_cc", cycle_count, 499);
    chk("t5_late_addr", bus.trace_addr, 7);
    chk("t5_late_cycle", bus.trace_cycle, 499);

    // T6 re-arm after pass clears FIFO; reset mid-run clears at once
    arm();
    chk("t6_pass_clr", pass, 0);
    chk("t6_fifo_clr", bus.trace_valid, 0);
    for (int i = 0; i < 3; i++) wr(5'(i + 1), 64'(i + 10));
    chk("t6_valid", bus.trace_valid, 1);
    chk("t6_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus.trace_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cc", cycle_count, 0);
    chk("t6_rst_data", bus.trace_data, 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_valid", bus.trace_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
